// File: rtl/axis_vtc_pkg.sv
// Shared types and timing helpers for the AXI4-Stream <-> parallel video converters.
package axis_vtc_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_SYNC,
      S_PRE,
      S_ACT,
      S_HBLK,
      S_POST
   } state_t;

   function automatic int h_total(input int h_active, input int h_blank);
      return h_active + h_blank;
   endfunction

   function automatic int f_total(input int h_active, input int h_blank,
                                  input int v_pre, input int v_active, input int v_post);
      return (v_pre + v_active + v_post) * h_total(h_active, h_blank);
   endfunction

endpackage

// File: rtl/vtc_hv_cnt.sv
// Horizontal/vertical position counter pair; limits and clears come from the owning FSM.
module vtc_hv_cnt
   import axis_vtc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_line_clr,
   input  logic             i_v_inc,
   input  logic [CNT_W-1:0] i_h_last,
   input  logic [CNT_W-1:0] i_v_last,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt,
   output logic             o_line_end,
   output logic             o_done
);

   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (i_clr) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_h_cnt <= i_line_clr ? '0 : r_h_cnt + 1'b1;
         if (i_v_inc)
            r_v_cnt <= r_v_cnt + 1'b1;
      end
   end

   assign o_h_cnt    = r_h_cnt;
   assign o_v_cnt    = r_v_cnt;
   assign o_line_end = (r_h_cnt == i_h_last);
   assign o_done     = o_line_end && (r_v_cnt == i_v_last);

endmodule

// File: rtl/axis2video.sv
// AXI4-Stream to parallel video: locks onto tuser, then replays raster timing with
// programmable blanking; timing never stalls, missing beats become underflow slots.
module axis2video
   import axis_vtc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int H_ACTIVE   = 1920,
   parameter int H_BLANK    = 280,
   parameter int V_ACTIVE   = 1080,
   parameter int V_PRE      = 4,
   parameter int V_POST     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  en_out,
   output logic                  vs_out,
   output logic                  underflow,
   output logic                  sof_err,
   output logic                  eol_err,
   output logic [15:0]           drop_cnt
);

   localparam logic [CNT_W-1:0] C_LINE_LAST = CNT_W'(h_total(H_ACTIVE, H_BLANK) - 1);
   localparam logic [CNT_W-1:0] C_HACT_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] C_HBLK_LAST = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] C_VPRE_LAST = CNT_W'(V_PRE - 1);
   localparam logic [CNT_W-1:0] C_VACT_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] C_VPST_LAST = CNT_W'(V_POST - 1);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_en;
   logic                  r_vs;
   logic                  r_underflow;
   logic                  r_sof_err;
   logic                  r_eol_err;
   logic [15:0]           r_drop_cnt;

   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   logic [CNT_W-1:0] w_h_last;
   logic [CNT_W-1:0] w_v_last;
   logic             w_line_end;
   logic             w_done;
   logic             w_clr;
   logic             w_line_clr;
   logic             w_v_inc;
   logic             w_act;
   logic             w_beat;

   vtc_hv_cnt u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr),
      .i_line_clr (w_line_clr),
      .i_v_inc    (w_v_inc),
      .i_h_last   (w_h_last),
      .i_v_last   (w_v_last),
      .o_h_cnt    (w_h_cnt),
      .o_v_cnt    (w_v_cnt),
      .o_line_end (w_line_end),
      .o_done     (w_done)
   );

   assign w_act  = (r_state == S_ACT);
   assign w_beat = w_act && s_axis_tvalid;

   // NOTE: every output gets a default first, so no path through the case infers a latch.
   always_comb begin
      w_h_last      = C_LINE_LAST;
      w_v_last      = C_VACT_LAST;
      w_clr         = 1'b0;
      w_line_clr    = 1'b0;
      w_v_inc       = 1'b0;
      s_axis_tready = 1'b0;
      case (r_state)
         S_SYNC: begin
            w_clr         = 1'b1;
            s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
         end
         S_PRE, S_POST: begin
            w_v_last = (r_state == S_PRE) ? C_VPRE_LAST : C_VPST_LAST;
            if (w_done) begin
               w_clr = 1'b1;
            end else if (w_line_end) begin
               w_line_clr = 1'b1;
               w_v_inc    = 1'b1;
            end
         end
         S_ACT: begin
            w_h_last      = C_HACT_LAST;
            w_line_clr    = w_line_end;
            s_axis_tready = 1'b1;
         end
         S_HBLK: begin
            w_h_last = C_HBLK_LAST;
            if (w_done) begin
               w_clr = 1'b1;
            end else if (w_line_end) begin
               w_line_clr = 1'b1;
               w_v_inc    = 1'b1;
            end
         end
         default: w_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_SYNC;
         r_dout      <= '0;
         r_en        <= 1'b0;
         r_vs        <= 1'b0;
         r_underflow <= 1'b0;
         r_sof_err   <= 1'b0;
         r_eol_err   <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_vs        <= (r_state == S_PRE) || (r_state == S_ACT) || (r_state == S_HBLK);
         r_en        <= w_act;
         r_dout      <= w_beat ? s_axis_tdata : '0;
         r_underflow <= w_act && !s_axis_tvalid;
         r_sof_err   <= w_beat && s_axis_tuser && !((w_h_cnt == '0) && (w_v_cnt == '0));
         // In S_ACT the line-end strobe is exactly "last pixel slot of the line".
         r_eol_err   <= w_beat && (s_axis_tlast != w_line_end);

         if ((r_state == S_SYNC) && s_axis_tvalid && !s_axis_tuser && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;

         case (r_state)
            S_SYNC:  if (s_axis_tvalid && s_axis_tuser) r_state <= S_PRE;
            S_PRE:   if (w_done)                        r_state <= S_ACT;
            S_ACT:   if (w_line_end)                    r_state <= S_HBLK;
            S_HBLK:  if (w_line_end)                    r_state <= w_done ? S_POST : S_ACT;
            S_POST:  if (w_done)                        r_state <= S_SYNC;
            default:                                    r_state <= S_SYNC;
         endcase
      end
   end

   assign dout      = r_dout;
   assign en_out    = r_en;
   assign vs_out    = r_vs;
   assign underflow = r_underflow;
   assign sof_err   = r_sof_err;
   assign eol_err   = r_eol_err;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_axis2video.sv
// Scoreboard bench for axis2video: a driver feeds queued beats, a monitor checks every
// active slot against expected records and measures frame shape.
module tb_axis2video;

   localparam int DW        = 16;
   localparam int HA        = 8;
   localparam int HB        = 4;
   localparam int VA        = 4;
   localparam int VP        = 2;
   localparam int VO        = 2;
   localparam int HT        = HA + HB;
   localparam int VS_CYC    = (VP + VA) * HT;
   localparam int FRAME_CYC = 1 + (VP + VA + VO) * HT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tuser = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] dout;
   logic          en_out;
   logic          vs_out;
   logic          underflow;
   logic          sof_err;
   logic          eol_err;
   logic [15:0]   drop_cnt;

   typedef struct {
      logic [15:0] data;
      logic        user;
      logic        last;
      logic        gap;
   } beat_t;

   typedef struct {
      logic [15:0] data;
      logic        uf;
      logic        sof;
      logic        eol;
   } slot_t;

   beat_t beat_q[$];
   slot_t exp_q[$];
   int    rise_q[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;

   axis2video #(
      .DATA_WIDTH (DW),
      .H_ACTIVE   (HA),
      .H_BLANK    (HB),
      .V_ACTIVE   (VA),
      .V_PRE      (VP),
      .V_POST     (VO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .dout          (dout),
      .en_out        (en_out),
      .vs_out        (vs_out),
      .underflow     (underflow),
      .sof_err       (sof_err),
      .eol_err       (eol_err),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One frame of HA x VA beats; optional hole, stray tuser and extra tlast positions.
   task automatic push_frame(input logic [15:0] base, input int gap_l, input int gap_p,
                             input int sof_l, input int sof_p, input int eol_l, input int eol_p);
      beat_t b;
      slot_t s;
      bit    first, stray, xlast;
      for (int l = 0; l < VA; l++) begin
         for (int p = 0; p < HA; p++) begin
            first = (l == 0) && (p == 0);
            stray = (l == sof_l) && (p == sof_p);
            xlast = (l == eol_l) && (p == eol_p);
            if ((l == gap_l) && (p == gap_p)) begin
               b.data = '0; b.user = 1'b0; b.last = 1'b0; b.gap = 1'b1;
               s.data = '0; s.uf = 1'b1; s.sof = 1'b0; s.eol = 1'b0;
            end else begin
               b.data = base + 16'(l * HA + p);
               b.user = first || stray;
               b.last = (p == HA - 1) || xlast;
               b.gap  = 1'b0;
               s.data = b.data;
               s.uf   = 1'b0;
               s.sof  = stray && !first;
               s.eol  = xlast && (p != HA - 1);
            end
            beat_q.push_back(b);
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic push_junk(input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = 16'hDEAD; b.user = 1'b0; b.last = 1'b0; b.gap = 1'b0;
         beat_q.push_back(b);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((beat_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({"drain_", name}, 32'(beat_q.size() + exp_q.size()), 32'd0);
      repeat (HB + VO * HT + 4) @(negedge clk);
   endtask

   // Driver: presents the head beat; a gap entry holds tvalid low for one ready slot.
   initial begin : driver
      beat_t b;
      forever begin
         @(negedge clk);
         if (beat_q.size() == 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tdata  = '0;
         end else begin
            b = beat_q[0];
            s_axis_tvalid = !b.gap;
            s_axis_tuser  = b.user;
            s_axis_tlast  = b.last;
            s_axis_tdata  = b.data;
            #1;
            if (rst_n && s_axis_tready) void'(beat_q.pop_front());
         end
      end
   end

   // Monitor: slot-by-slot scoreboard plus raster shape measurement.
   initial begin : monitor
      slot_t e;
      bit    in_frame;
      bit    prev_en;
      int    vs_len, en_run, gap_run, bursts;
      in_frame = 0; prev_en = 0; vs_len = 0; en_run = 0; gap_run = 0; bursts = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 0;
            prev_en  = 0;
         end else begin
            if (en_out) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_en", 32'(en_out), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("dout",      32'(dout),      32'(e.data));
                  check("underflow", 32'(underflow), 32'(e.uf));
                  check("sof_err",   32'(sof_err),   32'(e.sof));
                  check("eol_err",   32'(eol_err),   32'(e.eol));
               end
            end else if (vs_out) begin
               check("blank_outputs", {13'd0, underflow, sof_err, eol_err, dout}, 32'd0);
            end
            if (vs_out && !in_frame) begin
               in_frame = 1; vs_len = 0; bursts = 0; gap_run = 0; en_run = 0;
               rise_q.push_back(cyc);
            end
            if (in_frame && vs_out) begin
               if (en_out && !prev_en) begin
                  if (bursts == 0) check("first_en_offset", vs_len, VP * HT);
                  else             check("hblank_gap", gap_run, HB);
                  bursts++;
                  en_run = 0;
               end
               if (en_out) begin
                  en_run++;
               end else if (prev_en) begin
                  check("en_burst_len", en_run, HA);
                  gap_run = 1;
               end else begin
                  gap_run++;
               end
               vs_len++;
            end else if (in_frame) begin
               check("vs_len", vs_len, VS_CYC);
               check("en_bursts", bursts, VA);
               in_frame = 0;
            end
            prev_en = en_out;
         end
      end
   end

   initial begin : watchdog
      #(1_500_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      repeat (3) @(negedge clk);
      check("rst_dout",      32'(dout),      32'd0);
      check("rst_en",        32'(en_out),    32'd0);
      check("rst_vs",        32'(vs_out),    32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_sof_err",   32'(sof_err),   32'd0);
      check("rst_eol_err",   32'(eol_err),   32'd0);
      check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
      rst_n = 1'b1;

      // Nominal frame, pixels 0..31.
      push_frame(16'h0000, -1, -1, -1, -1, -1, -1);
      wait_idle("nominal", 3000);
      check("drop_nominal", 32'(drop_cnt), 32'd0);

      // Garbage before SOF is discarded and counted.
      push_junk(5);
      push_frame(16'h0080, -1, -1, -1, -1, -1, -1);
      wait_idle("garbage", 3000);
      check("drop_garbage", 32'(drop_cnt), 32'd5);

      // Source skips pixel 3 of line 1.
      push_frame(16'h0100, 1, 3, -1, -1, -1, -1);
      wait_idle("underflow", 3000);

      // Early tlast on line 2 pixel 5, junk, then a clean frame.
      push_frame(16'h0200, -1, -1, -1, -1, 2, 5);
      push_junk(3);
      push_frame(16'h0300, -1, -1, -1, -1, -1, -1);
      wait_idle("early_tlast", 4000);
      check("drop_realign", 32'(drop_cnt), 32'd8);

      // Stray tuser on line 1 pixel 0.
      push_frame(16'h0400, -1, -1, 1, 0, -1, -1);
      wait_idle("stray_tuser", 3000);

      // Asynchronous reset while active pixels are flowing.
      push_frame(16'h0500, -1, -1, -1, -1, -1, -1);
      n = 0;
      while (!en_out && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("en_before_reset", 32'(en_out), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_dout", 32'(dout),   32'd0);
      check("async_rst_en",   32'(en_out), 32'd0);
      check("async_rst_vs",   32'(vs_out), 32'd0);
      beat_q.delete();
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("async_rst_drop", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      push_frame(16'h0600, -1, -1, -1, -1, -1, -1);
      wait_idle("after_reset", 3000);

      // Back-to-back SOF gives the minimum frame period.
      rise_q.delete();
      push_frame(16'h0700, -1, -1, -1, -1, -1, -1);
      push_frame(16'h0720, -1, -1, -1, -1, -1, -1);
      wait_idle("back_to_back", 4000);
      check("vs_rises", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() >= 2) check("frame_period", 32'(rise_q[1] - rise_q[0]), 32'(FRAME_CYC));

      // drop_cnt saturates instead of wrapping.
      push_junk(65540);
      wait_idle("saturation", 70000);
      check("drop_saturated", 32'(drop_cnt), 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
